// File: rtl/alu_pkg.sv
// Shared definitions for the ALU program sequencer: instruction layout, type codes, FSM states.
package alu_pkg;

    localparam int INSTR_W = 21;

    localparam logic [2:0] ALU_ADD = 3'b100;

    typedef enum logic [2:0] {
        IT_EXEC = 3'b000,
        IT_JMP  = 3'b001,
        IT_JZ   = 3'b010,
        IT_JNZ  = 3'b011,
        IT_JN   = 3'b100,
        IT_JC   = 3'b101,
        IT_NOP  = 3'b110,
        IT_HALT = 3'b111
    } itype_e;

    // Field order is the bit layout of the word, MSB first: [20] cin, [19:17] type,
    // [16:14] op, [13:11] a_addr, [10:8] b_addr, [7:0] constant / branch target.
    typedef struct packed {
        logic       cin;
        itype_e     itype;
        logic [2:0] op;
        logic [2:0] a_addr;
        logic [2:0] b_addr;
        logic [7:0] konst;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

endpackage

// File: rtl/alu_seq_pmem.sv
// Program store for the sequencer: synchronous write, combinational read, never cleared by reset.
module alu_seq_pmem
    import alu_pkg::*;
#(
    parameter int PC_W = 5
) (
    input  logic               clk,
    input  logic               we,
    input  logic [PC_W-1:0]    waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [PC_W-1:0]    raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem_q [2**PC_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_seq.sv
// Program sequencer driving the ALU control interface from a loadable program memory,
// with conditional branches on the ALU flags.
//
//   state   | meaning
//   IDLE    | after reset, waiting for start; program memory writable
//   RUN     | decoding the word at pc every cycle
//   WAIT    | conditional branch stalled until the last EXEC's flags are valid
//   HALTED  | program hit HALT; alu outputs hold, memory writable, start restarts at 0
module alu_seq
    import alu_pkg::*;
#(
    parameter int PC_W     = 5,
    parameter int FLAG_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               zero,
    input  logic               neg,
    input  logic               cout,
    input  logic               ovf,
    output logic [2:0]         a_addr,
    output logic [2:0]         b_addr,
    output logic [7:0]         alu_const,
    output logic [2:0]         op,
    output logic               cin,
    output logic               alu_we,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               halted
);

    localparam int              AGE_W   = $clog2(FLAG_LAT + 2);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(FLAG_LAT);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [2:0]         a_q, a_d, b_q, b_d, op_q, op_d;
    logic [7:0]         const_q, const_d;
    logic               cin_q, cin_d, we_q, we_d;
    logic [AGE_W-1:0]   age_q, age_d;

    logic [INSTR_W-1:0] rdata;
    instr_t             instr;
    logic [PC_W-1:0]    pc_inc, target;
    logic [3:0]         flags_v;
    logic [1:0]         flag_idx;
    logic               flag_inv, taken, mem_we;

    assign mem_we = prog_we && (state_q == ST_IDLE || state_q == ST_HALTED);

    alu_seq_pmem #(.PC_W(PC_W)) u_pmem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_q),
        .rdata (rdata)
    );

    assign instr   = instr_t'(rdata);
    // ovf sits in the vector so it is visible to status, but no branch type selects it.
    assign flags_v = {ovf, cout, neg, zero};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        const_d  = const_q;
        cin_d    = cin_q;
        we_d     = 1'b0;
        age_d    = (age_q == AGE_MAX) ? age_q : age_q + AGE_W'(1);
        pc_inc   = pc_q + PC_W'(1);
        target   = instr.konst[PC_W-1:0];
        flag_idx = 2'd0;
        flag_inv = 1'b0;

        case (instr.itype)
            IT_JNZ:  flag_inv = 1'b1;
            IT_JN:   flag_idx = 2'd1;
            IT_JC:   flag_idx = 2'd2;
            default: flag_idx = 2'd0;
        endcase
        taken = flags_v[flag_idx] ^ flag_inv;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                end
            end
            ST_RUN: begin
                case (instr.itype)
                    IT_EXEC: begin
                        op_d    = instr.op;
                        a_d     = instr.a_addr;
                        b_d     = instr.b_addr;
                        const_d = instr.konst;
                        cin_d   = instr.cin;
                        we_d    = 1'b1;
                        pc_d    = pc_inc;
                        age_d   = '0;
                    end
                    IT_JMP:  pc_d = target;
                    IT_NOP:  pc_d = pc_inc;
                    IT_HALT: state_d = ST_HALTED;
                    default: begin
                        if (age_q != AGE_MAX) begin
                            state_d = ST_WAIT;
                        end else begin
                            pc_d = taken ? target : pc_inc;
                        end
                    end
                endcase
            end
            ST_WAIT: begin
                // Leave as the counter reaches its limit so the re-decode sees valid flags.
                if (age_d == AGE_MAX) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            const_q <= '0;
            cin_q   <= 1'b0;
            we_q    <= 1'b0;
            age_q   <= AGE_MAX;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            const_q <= const_d;
            cin_q   <= cin_d;
            we_q    <= we_d;
            age_q   <= age_d;
        end
    end

    assign a_addr    = a_q;
    assign b_addr    = b_q;
    assign alu_const = const_q;
    assign op        = op_q;
    assign cin       = cin_q;
    assign alu_we    = we_q;
    assign pc        = pc_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_WAIT);
    assign halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a small ALU register model and an issue scoreboard.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int PC_W = 5;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               prog_we = 1'b0;
    logic [PC_W-1:0]    prog_addr = '0;
    logic [INSTR_W-1:0] prog_data = '0;
    logic               zero = 1'b0, neg = 1'b0, cout = 1'b0, ovf = 1'b0;
    logic [2:0]         a_addr, b_addr, op;
    logic [7:0]         alu_const;
    logic               cin, alu_we, busy, halted;
    logic [PC_W-1:0]    pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [7:0] y;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        itype_e     t;
        logic       z, n, c;
        logic [4:0] exp_pc;
    } br_t;

    logic [7:0] r [8];

    alu_seq #(.PC_W(PC_W), .FLAG_LAT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .zero      (zero),
        .neg       (neg),
        .cout      (cout),
        .ovf       (ovf),
        .a_addr    (a_addr),
        .b_addr    (b_addr),
        .alu_const (alu_const),
        .op        (op),
        .cin       (cin),
        .alu_we    (alu_we),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [INSTR_W-1:0] enc(input logic c, input itype_e t, input logic [2:0] o,
                                              input logic [2:0] a, input logic [2:0] b,
                                              input logic [7:0] k);
        instr_t i;
        i = '{cin: c, itype: t, op: o, a_addr: a, b_addr: b, konst: k};
        return i;
    endfunction

    task automatic load(input int addr, input logic [INSTR_W-1:0] d);
        prog_we   = 1'b1;
        prog_addr = PC_W'(addr);
        prog_data = d;
        step();
        prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        br_t  br_tab[8];
        exp_t e;
        logic [7:0] y;

        // Reset
        rst = 1'b1;
        step();
        step();
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_we", 32'(alu_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_alu_bus", 32'({cin, op, a_addr, b_addr, alu_const}), 32'd0);
        rst = 1'b0;

        // Straight line: EXEC then HALT
        load(0, enc(1'b0, IT_EXEC, ALU_ADD, 3'd0, 3'd1, 8'd1));
        load(1, enc(1'b0, IT_HALT, 3'd0, 3'd0, 3'd0, 8'd0));
        pulse_start();
        chk("sl_run_pc", 32'({busy, alu_we, pc}), 32'({1'b1, 1'b0, 5'd0}));
        step();
        chk("sl_issue", 32'({alu_we, cin, op, a_addr, b_addr, alu_const}),
            32'({1'b1, 1'b0, ALU_ADD, 3'd0, 3'd1, 8'd1}));
        chk("sl_issue_pc", 32'(pc), 32'd1);
        step();
        chk("sl_halt", 32'({halted, busy, alu_we, pc}), 32'({1'b1, 1'b0, 1'b0, 5'd1}));
        chk("sl_hold", 32'({op, a_addr, b_addr, alu_const}), 32'({ALU_ADD, 3'd0, 3'd1, 8'd1}));

        // Fibonacci loop against the register model
        load(0, enc(1'b0, IT_EXEC, ALU_ADD, 3'd0, 3'd1, 8'd0));
        load(1, enc(1'b0, IT_EXEC, ALU_ADD, 3'd1, 3'd0, 8'd0));
        load(2, enc(1'b0, IT_JMP, 3'd0, 3'd0, 3'd0, 8'd0));
        for (int i = 0; i < 8; i++) r[i] = 8'd0;
        r[0] = 8'd1;
        sb.push_back('{3'd0, 3'd1, 8'd1});
        sb.push_back('{3'd1, 3'd0, 8'd1});
        sb.push_back('{3'd0, 3'd1, 8'd2});
        sb.push_back('{3'd1, 3'd0, 8'd3});
        sb.push_back('{3'd0, 3'd1, 8'd5});
        sb.push_back('{3'd1, 3'd0, 8'd8});
        sb.push_back('{3'd0, 3'd1, 8'd13});
        pulse_start();
        for (int cyc = 0; cyc < 30 && sb.size() > 0; cyc++) begin
            step();
            chk("fib_we", 32'(alu_we), 32'((cyc % 3) != 2));
            if (alu_we) begin
                y = r[a_addr] + r[b_addr];
                r[a_addr] = y;
                e = sb.pop_front();
                chk("fib_issue", 32'({a_addr, b_addr, y}), 32'({e.a, e.b, e.y}));
            end
        end
        chk("fib_drain", 32'(sb.size()), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Conditional branches with FLAG_LAT=2: one WAIT cycle, then taken -> 5, not taken -> 2
        load(0, enc(1'b0, IT_EXEC, ALU_ADD, 3'd0, 3'd1, 8'd0));
        load(2, enc(1'b0, IT_HALT, 3'd0, 3'd0, 3'd0, 8'd0));
        load(5, enc(1'b0, IT_HALT, 3'd0, 3'd0, 3'd0, 8'd0));
        br_tab[0] = '{IT_JZ,  1'b1, 1'b0, 1'b0, 5'd5};
        br_tab[1] = '{IT_JZ,  1'b0, 1'b1, 1'b1, 5'd2};
        br_tab[2] = '{IT_JNZ, 1'b0, 1'b1, 1'b1, 5'd5};
        br_tab[3] = '{IT_JNZ, 1'b1, 1'b0, 1'b0, 5'd2};
        br_tab[4] = '{IT_JN,  1'b0, 1'b1, 1'b0, 5'd5};
        br_tab[5] = '{IT_JN,  1'b1, 1'b0, 1'b1, 5'd2};
        br_tab[6] = '{IT_JC,  1'b0, 1'b0, 1'b1, 5'd5};
        br_tab[7] = '{IT_JC,  1'b1, 1'b1, 1'b0, 5'd2};
        for (int k = 0; k < 8; k++) begin
            load(1, enc(1'b0, br_tab[k].t, 3'd0, 3'd0, 3'd0, 8'd5));
            zero = br_tab[k].z;
            neg  = br_tab[k].n;
            cout = br_tab[k].c;
            pulse_start();
            step();
            chk("br_exec", 32'({alu_we, pc}), 32'({1'b1, 5'd1}));
            step();
            chk("br_wait", 32'({busy, alu_we, pc}), 32'({1'b1, 1'b0, 5'd1}));
            step();
            chk("br_redecode", 32'({busy, alu_we, pc}), 32'({1'b1, 1'b0, 5'd1}));
            step();
            chk("br_target", 32'(pc), 32'(br_tab[k].exp_pc));
            step();
            chk("br_halted", 32'({halted, pc}), 32'({1'b1, br_tab[k].exp_pc}));
        end
        zero = 1'b0;
        neg  = 1'b0;
        cout = 1'b0;

        // Wrap over all-NOP memory, write lockout and start ignored while busy
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int a = 0; a < 32; a++) load(a, enc(1'b0, IT_NOP, 3'd0, 3'd0, 3'd0, 8'd0));
        pulse_start();
        prog_we   = 1'b1;
        prog_addr = 5'd3;
        prog_data = enc(1'b0, IT_HALT, 3'd0, 3'd0, 3'd0, 8'd0);
        step();
        prog_we = 1'b0;
        chk("wrap_pc1", 32'(pc), 32'd1);
        for (int i = 2; i < 32; i++) begin
            start = (i == 10);
            step();
            start = 1'b0;
            chk("wrap_pc", 32'(pc), 32'(i));
        end
        step();
        chk("wrap_to_zero", 32'(pc), 32'd0);
        for (int i = 1; i < 5; i++) begin
            step();
            chk("wrap_lap2_pc", 32'(pc), 32'(i));
        end
        chk("wrap_no_halt", 32'({halted, busy}), 32'({1'b0, 1'b1}));

        // Reset while a branch is stalled in WAIT
        rst = 1'b1;
        step();
        rst = 1'b0;
        load(0, enc(1'b0, IT_EXEC, ALU_ADD, 3'd2, 3'd3, 8'd7));
        load(1, enc(1'b0, IT_JZ, 3'd0, 3'd0, 3'd0, 8'd5));
        load(5, enc(1'b0, IT_HALT, 3'd0, 3'd0, 3'd0, 8'd0));
        zero = 1'b1;
        pulse_start();
        step();
        step();
        chk("mid_wait", 32'({busy, alu_we, pc}), 32'({1'b1, 1'b0, 5'd1}));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_state", 32'({busy, halted, alu_we, pc}), 32'd0);
        chk("mid_rst_bus", 32'({cin, op, a_addr, b_addr, alu_const}), 32'd0);
        pulse_start();
        chk("mid_restart", 32'({busy, pc}), 32'({1'b1, 5'd0}));
        step();
        chk("mid_reissue", 32'({alu_we, a_addr, b_addr, alu_const, pc}),
            32'({1'b1, 3'd2, 3'd3, 8'd7, 5'd1}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Program sequencer that drives the ALU's control interface (a_addr, b_addr, const, op, cin) from an internal loadable program memory. It consumes the ALU status flags (zero, neg, cout, ovf) for conditional branches. It replaces hand-driven stimulus as the initiator of ALU operations, for example running the Fibonacci loop on-chip. It sits directly above alu: its outputs connect to alu's inputs, and alu's flag outputs feed back into it.

Parameters:
PC_W, 5, program-counter width; program depth = 2**PC_W (32 words)
FLAG_LAT, 1, clock cycles from an EXEC issue until the alu flags reflect that operation

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; starts execution at pc 0 from IDLE or HALTED
prog_we  input  1  program-memory write enable
prog_addr  input  PC_W  program-memory write address
prog_data  input  21  instruction word
zero  input  1  alu zero flag
neg  input  1  alu negative flag
cout  input  1  alu carry-out flag
ovf  input  1  alu overflow flag
a_addr  output  3  alu A register address
b_addr  output  3  alu B register address
const  output  8  alu constant operand
op  output  3  alu opcode
cin  output  1  alu carry-in
alu_we  output  1  high only while an EXEC instruction is presented to the alu
pc  output  PC_W  current program counter
busy  output  1  high in RUN or WAIT
halted  output  1  high in HALTED

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Instruction word fields:
  - [20] cin
  - [19:17] type: 000 EXEC, 001 JMP, 010 JZ, 011 JNZ, 100 JN, 101 JC, 110 NOP, 111 HALT
  - [16:14] op
  - [13:11] a_addr
  - [10:8] b_addr
  - [7:0] const
  - Branch target is const[PC_W-1:0].
- Program memory: 2**PC_W x 21 bits.
  - Write is synchronous on prog_we, honoured only in IDLE or HALTED; ignored while busy.
  - Read is combinational at pc. Contents are not cleared by rst.
- Reset values: state=IDLE, pc=0, all alu outputs 0, alu_we=0, busy=0, halted=0, flag-age counter=FLAG_LAT (saturated).
- State IDLE: on start, go to RUN with pc=0.
  - If prog_we and start occur in the same cycle, the write completes and the fetch in the next cycle sees the new word.
- State RUN: decode the word at pc each cycle. All alu outputs are registered, so they change 1 cycle after decode.
  - EXEC: drive op/a_addr/b_addr/const/cin from the word with alu_we=1; pc<=pc+1; flag-age counter<=0.
  - JMP: pc<=target; alu_we=0.
  - NOP: pc<=pc+1; alu_we=0.
  - Jcc (JZ/JNZ/JN/JC):
    - If flag-age < FLAG_LAT: go to WAIT, hold pc, alu_we=0.
    - Else: evaluate the flag (JZ zero=1, JNZ zero=0, JN neg=1, JC cout=1). Taken: pc<=target. Not taken: pc<=pc+1.
  - HALT: go to HALTED, pc holds, alu_we=0.
- Flag-age counter: increments each cycle when not at FLAG_LAT; saturates at FLAG_LAT.
- State WAIT: stay until flag-age = FLAG_LAT, then re-enter RUN at the same pc (the branch is re-decoded). alu_we=0 throughout.
- State HALTED: halted=1, alu_we=0; alu outputs other than alu_we hold their last values. start restarts at pc 0 via RUN.
- pc arithmetic: pc+1 wraps from 2**PC_W-1 to 0, with no error.
- Mid-operation events:
  - start while busy: ignored.
  - rst mid-program: all state returns to reset values on the next edge, and any pending WAIT is abandoned.
- ovf is registered for status only; no branch tests it in this revision.

Decomposition:
- Shared package alu_pkg:
  - instruction type codes (EXEC..HALT)
  - ALU opcode constants, including ADD=3'b100
  - field bit positions
  - INSTR_W=21
- One sub-module, alu_seq_pmem: the program memory (sync write, async read).
- FSM, pc and decode stay in alu_seq.

Test Plan:
- Reset: assert rst 2 cycles -> pc=0, alu_we=0, busy=0, halted=0, all alu outputs 0.
- Straight line:
  - Stimulus: load pc0 EXEC op=100 a=0 b=1 const=1; pc1 HALT; pulse start.
  - Response: next cycle op=100, a_addr=0, b_addr=1, const=1, alu_we=1; following cycle halted=1, alu_we=0, pc=1.
- Fibonacci loop:
  - Stimulus: pc0 EXEC op=100 a=0 b=1; pc1 EXEC op=100 a=1 b=0; pc2 JMP 0. Feed the alu model.
  - Response: alu_we pattern 1,1,0 repeating; a/b addresses alternate 0/1; the alu model's y sequence is 1,1,2,3,5,8,13.
- Conditional wait:
  - Stimulus: EXEC at pc0, JZ target=5 at pc1, FLAG_LAT=2, zero=1.
  - Response: one WAIT cycle with pc=1, busy=1, alu_we=0; then pc=5. Repeat with zero=0 -> pc=2.
- Wrap and write lockout:
  - Stimulus: NOPs filling all 32 words; prog_we to addr 3 while busy.
  - Response: pc goes 31 -> 0; word 3 unchanged.
- Reset mid-run: assert rst while in WAIT -> next cycle state=IDLE, pc=0, alu_we=0; start then resumes from pc 0.
